wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback and a long-latency unit (LLU, e.g. mul/div) that completes out of band.
- The pipeline writeback always has priority. LLU results wait in a small FIFO.
- The FIFO has a starvation guard that requests a pipeline stall. A hazard query lets decode avoid RAW/WAW conflicts with queued results.
- Sits between WB_stage / LLU and the register file.

Parameters:
- DEPTH, 4, LLU result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, cycles a non-empty FIFO head may wait before stall_req_o asserts (≥1)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pipe_we_i  in  1  RegWrite from WB stage
- pipe_rd_i  in  REG_ADDR_WIDTH  WB destination register
- pipe_data_i  in  DATA_WIDTH  WB write data
- llu_valid_i  in  1  LLU result valid
- llu_rd_i  in  REG_ADDR_WIDTH  LLU destination register
- llu_data_i  in  DATA_WIDTH  LLU result
- llu_ready_o  out  1  FIFO can accept a result
- query_rs1_i  in  REG_ADDR_WIDTH  decode source 1
- query_rs2_i  in  REG_ADDR_WIDTH  decode source 2
- query_rd_i  in  REG_ADDR_WIDTH  decode destination
- hazard_o  out  1  a query register matches a queued FIFO entry
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  REG_ADDR_WIDTH  register-file write address
- rf_wdata_o  out  DATA_WIDTH  register-file write data
- rf_src_o  out  rf_src_e  which source owns the port this cycle
- stall_req_o  out  1  registered request to upstream to inject one or more bubbles

Behaviour:
- Reset (async, rst_n=0):
  - FIFO pointers and count cleared; starvation counter cleared; stall_req_o=0.
  - With the FIFO empty: llu_ready_o=1 and hazard_o=0.
- Effective pipeline write: pipe_act = pipe_we_i && pipe_rd_i!=0. Writes to x0 never reach the port.
- Port mux (combinational, 0-cycle latency from pipe inputs):
  - If pipe_act: rf_we_o=1, address/data from pipe, rf_src_o=SRC_PIPE.
  - Else if FIFO non-empty: pop the head, rf_we_o=1, address/data from head, rf_src_o=SRC_LLU.
  - Else: rf_we_o=0, address/data=0, rf_src_o=SRC_NONE.
- LLU handshake:
  - llu_ready_o = !full. Enqueue on llu_valid_i && llu_ready_o.
  - A result with llu_rd_i==0 is accepted and discarded (not enqueued).
  - Minimum LLU-to-port latency: 1 cycle.
- Full FIFO: llu_ready_o=0 even if a pop occurs in the same cycle. There is no full pass-through.
- Simultaneous push and pop with count in 1..DEPTH-1: count unchanged; the pushed entry goes behind the existing ones.
- Pointers wrap modulo DEPTH.
- FIFO order is strict; LLU results retire in acceptance order.
- hazard_o (combinational):
  - OR over valid FIFO entries of (entry.rd==query_rs1_i || entry.rd==query_rs2_i || entry.rd==query_rd_i).
  - Matches where the query register is 0 are ignored.
  - The entry being popped this cycle still counts.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs; saturates at STARVE_LIMIT.
  - Clears on any pop or when the FIFO is empty.
  - stall_req_o is registered: it becomes 1 the cycle after the counter reaches STARVE_LIMIT and holds until the cycle after the next pop.
- Upstream contract: while stall_req_o=1, upstream guarantees pipe_we_i=0 within 3 cycles.

Optional Feature:
- Macro: WBARB_BYPASS_EN.
- Defined: when FIFO empty, !pipe_act and the LLU handshake fires with llu_rd_i!=0, the result writes the port in the same cycle (rf_src_o=SRC_LLU) and is not enqueued. Latency 0.
- Undefined: all LLU results pass through the FIFO (latency ≥1).

Decomposition:
- core_pkg gets:
  - typedef enum logic [1:0] rf_src_e {SRC_NONE, SRC_PIPE, SRC_LLU}.
  - typedef struct llu_entry_t {rd, data}.
- Reuses DATA_WIDTH and REG_ADDR_WIDTH.
- One sub-module: wb_llu_fifo (parameterised DEPTH, push/pop/full/empty/count, exposes all entries for the hazard compare).

Test Plan:
- Reset then idle → llu_ready_o=1, rf_we_o=0, rf_src_o=SRC_NONE, stall_req_o=0, hazard_o=0.
- Pipe idle, LLU pushes rd=5 data=0xDEAD_BEEF → next cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF, SRC_LLU; with BYPASS_EN the write occurs the same cycle.
- Pipe writes x3 continuously while the LLU pushes 4 results (DEPTH=4) → llu_ready_o=0 after the 4th push; all pipe writes win; once the pipe idles, the 4 entries drain in order over 4 cycles.
- FIFO holds rd=7; query_rs2_i=7 → hazard_o=1; query all zero with an entry rd=0 pushed → discarded, hazard_o=0.
- Pipe writes every cycle with 1 queued entry, STARVE_LIMIT=8 → stall_req_o rises 9 cycles after enqueue; drop pipe_we_i → pop, stall_req_o falls the following cycle.
- Assert rst_n=0 mid-drain with 3 entries queued → outputs immediately return to reset values; after release, no stale entry is written.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types for the writeback port arbiter.
// Register/data widths, write-port source tag, LLU FIFO entry.
package core_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_LLU  = 2'd2
  } rf_src_e;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
  } llu_entry_t;

endpackage

// File: rtl/wb_llu_fifo.sv
// LLU result FIFO; DEPTH entries (power of two, >=2).
// Ports: push_i/din_i, pop_i/head_o, full_o, empty_o, count_o,
// entries_o/valid_o expose all slots for hazard compare.
module wb_llu_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  llu_entry_t             din_i,
  input  logic                   pop_i,
  output llu_entry_t             head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [PW:0]            count_o,
  output llu_entry_t [DEPTH-1:0] entries_o,
  output logic [DEPTH-1:0]       valid_o
);

  llu_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]          wr_q, rd_q;
  logic [PW:0]            cnt_q, cnt_d;
  logic                   do_push, do_pop;

  assign full_o    = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign head_o    = mem_q[rd_q];
  assign entries_o = mem_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Slot i is live when its distance from the read pointer
  // is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PW-1:0] off;
    assign off        = PW'(i) - rd_q;
    assign valid_o[i] = ({1'b0, off} < cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipe WB wins, LLU results queue.
// Ports: pipe_*_i, llu_*_i/llu_ready_o, query_*_i/hazard_o, rf_*_o,
// stall_req_o. Optional macro WBARB_BYPASS_EN: 0-cycle LLU bypass.
module wb_port_arbiter
  import core_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pipe_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] pipe_rd_i,
  input  logic [DATA_WIDTH-1:0]     pipe_data_i,
  input  logic                      llu_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] llu_rd_i,
  input  logic [DATA_WIDTH-1:0]     llu_data_i,
  output logic                      llu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] query_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] query_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] query_rd_i,
  output logic                      hazard_o,
  output logic                      rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0]     rf_wdata_o,
  output rf_src_e                   rf_src_o,
  output logic                      stall_req_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  llu_entry_t             head, din;
  llu_entry_t [DEPTH-1:0] ents;
  logic [DEPTH-1:0]       vld;
  logic [PW:0]            fcnt;
  logic                   full, empty;
  logic                   pipe_act, push, pop, byp;
  logic [CW-1:0]          starve_q, starve_d;
  logic                   stall_q, stall_d;

  assign pipe_act    = pipe_we_i && (pipe_rd_i != '0);
  assign llu_ready_o = !full;
  assign pop         = !pipe_act && !empty;

`ifdef WBARB_BYPASS_EN
  assign byp = empty && !pipe_act && llu_valid_i
            && llu_ready_o && (llu_rd_i != '0);
`else
  assign byp = 1'b0;
`endif

  // rd==x0 results are acknowledged but dropped here.
  assign push = llu_valid_i && llu_ready_o
             && (llu_rd_i != '0) && !byp;
  assign din  = '{rd: llu_rd_i, data: llu_data_i};

  wb_llu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .din_i    (din),
    .pop_i    (pop),
    .head_o   (head),
    .full_o   (full),
    .empty_o  (empty),
    .count_o  (fcnt),
    .entries_o(ents),
    .valid_o  (vld)
  );

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    rf_src_o   = SRC_NONE;
    if (pipe_act) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = pipe_rd_i;
      rf_wdata_o = pipe_data_i;
      rf_src_o   = SRC_PIPE;
    end else if (!empty) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = head.rd;
      rf_wdata_o = head.data;
      rf_src_o   = SRC_LLU;
    end else if (byp) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = llu_rd_i;
      rf_wdata_o = llu_data_i;
      rf_src_o   = SRC_LLU;
    end
  end

  // The head being popped this cycle is still a valid slot.
  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (
          (query_rs1_i != '0 && ents[i].rd == query_rs1_i) ||
          (query_rs2_i != '0 && ents[i].rd == query_rs2_i) ||
          (query_rd_i  != '0 && ents[i].rd == query_rd_i)))
        hazard_o = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || fcnt == '0) starve_d = '0;
    else if (starve_q != CW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
  end

  always_comb begin
    stall_d = stall_q;
    if (pop) stall_d = 1'b0;
    else if (starve_q == CW'(STARVE_LIMIT)) stall_d = 1'b1;
  end

  assign stall_req_o = stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter (DEPTH=4, STARVE_LIMIT=8).
// Vector table + LLU scoreboard, then starvation and reset sequences.
module tb_wb_port_arbiter;
  import core_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic [4:0]  q1, q2, qd;
  logic        hazard, rf_we, stall;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  rf_src_e     rf_src;

  int pass_cnt = 0;
  int total_cnt = 0;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd), .pipe_data_i(pipe_data),
    .llu_valid_i(llu_valid), .llu_rd_i(llu_rd), .llu_data_i(llu_data),
    .llu_ready_o(llu_ready),
    .query_rs1_i(q1), .query_rs2_i(q2), .query_rd_i(qd),
    .hazard_o(hazard),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .rf_src_o(rf_src), .stall_req_o(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pwe; logic [4:0] prd; logic [31:0] pd;
    logic lv;  logic [4:0] lrd; logic [31:0] ld;
    logic [4:0] q1, q2, qd;
    logic we; logic [4:0] wa; logic [31:0] wd;
    rf_src_e src; logic rdy; logic hz;
  } vec_t;

  vec_t       vt[$];
  llu_entry_t sb[$];

  function automatic vec_t mk(
    logic pwe, logic [4:0] prd, logic [31:0] pd,
    logic lv, logic [4:0] lrd, logic [31:0] ld,
    logic [4:0] a, logic [4:0] b, logic [4:0] d,
    logic we, logic [4:0] wa, logic [31:0] wd,
    rf_src_e src, logic rdy, logic hz);
    vec_t v;
    v.pwe = pwe; v.prd = prd; v.pd = pd;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.q1 = a; v.q2 = b; v.qd = d;
    v.we = we; v.wa = wa; v.wd = wd;
    v.src = src; v.rdy = rdy; v.hz = hz;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask

  task automatic drive(input vec_t v);
    pipe_we = v.pwe; pipe_rd = v.prd; pipe_data = v.pd;
    llu_valid = v.lv; llu_rd = v.lrd; llu_data = v.ld;
    q1 = v.q1; q2 = v.q2; qd = v.qd;
  endtask

  task automatic idle();
    drive(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, SRC_NONE,1,0));
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    llu_entry_t e;
    string      n;
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_ready", llu_ready, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_src", rf_src, SRC_NONE);
    chk("rst_stall", stall, 0);
    chk("rst_hazard", hazard, 0);
    @(negedge clk); rst_n = 1'b1;
    next();

    vt.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, SRC_NONE,1,0));
`ifdef WBARB_BYPASS_EN
    vt.push_back(mk(0,0,0, 1,5,32'hDEADBEEF, 0,0,0,
                    1,5,32'hDEADBEEF, SRC_LLU,1,0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0,0, 0,0,0, SRC_NONE,1,0));
`else
    vt.push_back(mk(0,0,0, 1,5,32'hDEADBEEF, 0,0,0,
                    0,0,0, SRC_NONE,1,0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0,0,
                    1,5,32'hDEADBEEF, SRC_LLU,1,0));
`endif
    vt.push_back(mk(1,3,32'h11, 1,1,32'hA1, 0,0,0, 1,3,32'h11, SRC_PIPE,1,0));
    vt.push_back(mk(1,3,32'h12, 1,2,32'hA2, 0,0,0, 1,3,32'h12, SRC_PIPE,1,0));
    vt.push_back(mk(1,3,32'h13, 1,3,32'hA3, 0,0,0, 1,3,32'h13, SRC_PIPE,1,0));
    vt.push_back(mk(1,3,32'h14, 1,4,32'hA4, 0,0,0, 1,3,32'h14, SRC_PIPE,1,0));
    vt.push_back(mk(1,3,32'h15, 1,6,32'hA6, 2,0,0, 1,3,32'h15, SRC_PIPE,0,1));
    vt.push_back(mk(0,0,0, 1,6,32'hA6, 0,0,4, 1,1,32'hA1, SRC_LLU,0,1));
    vt.push_back(mk(0,0,0, 0,0,0, 1,0,0, 1,2,32'hA2, SRC_LLU,1,0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0,0, 1,3,32'hA3, SRC_LLU,1,0));
    vt.push_back(mk(0,0,0, 0,0,0, 4,0,0, 1,4,32'hA4, SRC_LLU,1,1));
    vt.push_back(mk(0,0,0, 0,0,0, 4,0,0, 0,0,0, SRC_NONE,1,0));
    vt.push_back(mk(1,3,32'h20, 1,7,32'h77, 0,0,0, 1,3,32'h20, SRC_PIPE,1,0));
    vt.push_back(mk(1,3,32'h21, 0,0,0, 0,7,0, 1,3,32'h21, SRC_PIPE,1,1));
    vt.push_back(mk(1,9,32'h22, 1,0,32'h99, 0,0,0, 1,9,32'h22, SRC_PIPE,1,0));
    vt.push_back(mk(1,0,32'h55, 0,0,0, 0,0,0, 1,7,32'h77, SRC_LLU,1,0));
    vt.push_back(mk(0,0,0, 0,0,0, 7,0,0, 0,0,0, SRC_NONE,1,0));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      #4;
      n = $sformatf("v%0d", i);
      chk({n, "_we"}, rf_we, vt[i].we);
      chk({n, "_waddr"}, rf_waddr, vt[i].wa);
      chk({n, "_wdata"}, rf_wdata, vt[i].wd);
      chk({n, "_src"}, rf_src, vt[i].src);
      chk({n, "_ready"}, llu_ready, vt[i].rdy);
      chk({n, "_hazard"}, hazard, vt[i].hz);
      if (vt[i].lv && vt[i].rdy && vt[i].lrd != 0)
        sb.push_back('{rd: vt[i].lrd, data: vt[i].ld});
      if (rf_src == SRC_LLU) begin
        if (sb.size() == 0) begin
          chk({n, "_sb_empty"}, 1, 0);
        end else begin
          e = sb.pop_front();
          chk({n, "_sb_rd"}, rf_waddr, e.rd);
          chk({n, "_sb_data"}, rf_wdata, e.data);
        end
      end
      next();
    end
    chk("sb_drained", sb.size(), 0);

    // Starvation: one queued entry, pipe writes every cycle.
    drive(mk(1,3,32'h30, 1,10,32'hC0, 0,0,0, 0,0,0, SRC_NONE,1,0));
    #4;
    chk("st_push_src", rf_src, SRC_PIPE);
    next();
    llu_valid = 0;
    for (int j = 1; j <= 11; j++) begin
      #4;
      chk($sformatf("st_stall_%0d", j), stall, (j >= 10) ? 1 : 0);
      chk($sformatf("st_src_%0d", j), rf_src, SRC_PIPE);
      next();
    end
    pipe_we = 0;
    #4;
    chk("st_pop_src", rf_src, SRC_LLU);
    chk("st_pop_addr", rf_waddr, 10);
    chk("st_pop_stall", stall, 1);
    next();
    #4;
    chk("st_fall", stall, 0);
    chk("st_empty", rf_we, 0);
    next();

    // Reset mid-drain with 3 entries queued.
    for (int k = 0; k < 3; k++) begin
      drive(mk(1,3,32'h40, 1,5'(11+k),32'hB0+k, 0,0,0,
               0,0,0, SRC_NONE,1,0));
      next();
    end
    idle();
    #4;
    chk("rd_first", rf_waddr, 11);
    next();
    q1 = 12;
    #1;
    chk("rd_pre_hz", hazard, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rd_rst_we", rf_we, 0);
    chk("rd_rst_src", rf_src, SRC_NONE);
    chk("rd_rst_ready", llu_ready, 1);
    chk("rd_rst_hz", hazard, 0);
    chk("rd_rst_stall", stall, 0);
    @(negedge clk); rst_n = 1'b1;
    next();
    for (int k = 0; k < 3; k++) begin
      #4;
      chk($sformatf("rd_post_we_%0d", k), rf_we, 0);
      chk($sformatf("rd_post_hz_%0d", k), hazard, 0);
      next();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
